// File: rtl/ir_queue_if.sv
// Bus bundle for the instruction prefetch queue.
// The master modport is the fetch/decode side. The slave modport is the queue itself.
interface ir_queue_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] IQ_in;
    logic             IQ_we;
    logic             IQ_ld;
    logic             IQ_flush;
    logic [WIDTH-1:0] IQ_out;
    logic             IQ_out_valid;
    logic             IQ_full;
    logic             IQ_empty;
    logic [CW-1:0]    IQ_count;
    logic             IQ_ovf;

    modport master (
        output IQ_in, IQ_we, IQ_ld, IQ_flush,
        input  IQ_out, IQ_out_valid, IQ_full, IQ_empty, IQ_count, IQ_ovf
    );

    modport slave (
        input  IQ_in, IQ_we, IQ_ld, IQ_flush,
        output IQ_out, IQ_out_valid, IQ_full, IQ_empty, IQ_count, IQ_ovf
    );
endinterface

// File: rtl/ir_queue.sv
// Instruction prefetch FIFO feeding a held output instruction register.
// Flush discards queued words but leaves the last loaded instruction visible.
module ir_queue #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic          IQ_clk,
    input  logic          IQ_rst_n,
    ir_queue_if.slave     bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0]    rptr_q, rptr_d;
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             out_valid_q, out_valid_d;
    logic             ovf_q, ovf_d;

    logic full, empty, pop, push;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    // Flush wins over everything. A pop frees a slot, so a push is legal on the same edge.
    assign pop  = ~bus.IQ_flush & bus.IQ_ld & ~empty;
    assign push = ~bus.IQ_flush & bus.IQ_we & (~full | pop);

    always_comb begin
        rptr_d      = rptr_q;
        wptr_d      = wptr_q;
        count_d     = count_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        ovf_d       = ovf_q;

        if (bus.IQ_flush) begin
            rptr_d      = '0;
            wptr_d      = '0;
            count_d     = '0;
            out_valid_d = 1'b0;
            ovf_d       = 1'b0;
        end else begin
            if (pop) begin
                out_d       = mem[rptr_q];
                out_valid_d = 1'b1;
                rptr_d      = rptr_q + 1'b1;
            end
            if (push) begin
                wptr_d = wptr_q + 1'b1;
            end
            if (bus.IQ_we && !push) begin
                ovf_d = 1'b1;
            end
            if (push && !pop) begin
                count_d = count_q + 1'b1;
            end else if (pop && !push) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge IQ_clk or negedge IQ_rst_n) begin
        if (!IQ_rst_n) begin
            rptr_q      <= '0;
            wptr_q      <= '0;
            count_q     <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            rptr_q      <= rptr_d;
            wptr_q      <= wptr_d;
            count_q     <= count_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            ovf_q       <= ovf_d;
        end
    end

    // Storage has no reset so it can map onto distributed/block RAM.
    always_ff @(posedge IQ_clk) begin
        if (push) begin
            mem[wptr_q] <= bus.IQ_in;
        end
    end

    assign bus.IQ_out       = out_q;
    assign bus.IQ_out_valid = out_valid_q;
    assign bus.IQ_full      = full;
    assign bus.IQ_empty     = empty;
    assign bus.IQ_count     = count_q;
    assign bus.IQ_ovf       = ovf_q;
endmodule

// File: tb/tb_ir_queue.sv
// Directed bench for ir_queue. A queue scoreboard holds the words expected to be
// in the FIFO, and each load pops from it the value IQ_out must take next.
module tb_ir_queue;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ir_queue_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    ir_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .IQ_clk   (clk),
        .IQ_rst_n (rst_n),
        .bus      (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] sb_q [$];
    logic [WIDTH-1:0] exp_out;
    logic             exp_valid;
    logic             exp_ovf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".count"}, 32'(bus.IQ_count), 32'(sb_q.size()));
        chk({tag, ".out"}, 32'(bus.IQ_out), 32'(exp_out));
        chk({tag, ".valid"}, 32'(bus.IQ_out_valid), 32'(exp_valid));
        chk({tag, ".ovf"}, 32'(bus.IQ_ovf), 32'(exp_ovf));
        chk({tag, ".full"}, 32'(bus.IQ_full), 32'(sb_q.size() == DEPTH));
        chk({tag, ".empty"}, 32'(bus.IQ_empty), 32'(sb_q.size() == 0));
        $display("%0t %s: count=%0d out=%02h valid=%0b ovf=%0b", $time, tag,
                 bus.IQ_count, bus.IQ_out, bus.IQ_out_valid, bus.IQ_ovf);
    endtask

    // One clock of stimulus. The scoreboard is updated from the pre-edge state.
    task automatic step(input string tag, input logic we, input logic [WIDTH-1:0] din,
                        input logic ld, input logic fl);
        logic do_pop;
        logic do_push;
        @(negedge clk);
        bus.IQ_we    = we;
        bus.IQ_in    = din;
        bus.IQ_ld    = ld;
        bus.IQ_flush = fl;
        if (fl) begin
            sb_q.delete();
            exp_valid = 1'b0;
            exp_ovf   = 1'b0;
        end else begin
            do_pop  = ld && (sb_q.size() > 0);
            do_push = we && ((sb_q.size() < DEPTH) || do_pop);
            if (we && !do_push) exp_ovf = 1'b1;
            if (do_pop) begin
                exp_out   = sb_q.pop_front();
                exp_valid = 1'b1;
            end
            if (do_push) sb_q.push_back(din);
        end
        @(posedge clk);
        #1;
        bus.IQ_we    = 1'b0;
        bus.IQ_ld    = 1'b0;
        bus.IQ_flush = 1'b0;
        check_all(tag);
    endtask

    task automatic model_reset();
        sb_q.delete();
        exp_out   = '0;
        exp_valid = 1'b0;
        exp_ovf   = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.IQ_in    = '0;
        bus.IQ_we    = 1'b0;
        bus.IQ_ld    = 1'b0;
        bus.IQ_flush = 1'b0;
        model_reset();
        #1;
        check_all("reset0");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Asynchronous reset mid-cycle after three pushes and one load
        step("r_push", 1'b1, 8'h11, 1'b0, 1'b0);
        step("r_push", 1'b1, 8'h22, 1'b0, 1'b0);
        step("r_push", 1'b1, 8'h33, 1'b0, 1'b0);
        step("r_load", 1'b0, 8'h00, 1'b1, 1'b0);
        chk("r_load.out11", 32'(bus.IQ_out), 32'h11);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("async_rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Fill and drain
        step("fill", 1'b1, 8'h11, 1'b0, 1'b0);
        step("fill", 1'b1, 8'h22, 1'b0, 1'b0);
        step("fill", 1'b1, 8'h33, 1'b0, 1'b0);
        step("fill", 1'b1, 8'h44, 1'b0, 1'b0);
        chk("fill.full_const", 32'(bus.IQ_full), 32'h1);
        chk("fill.count_const", 32'(bus.IQ_count), 32'd4);
        for (int i = 0; i < 4; i++) step("drain", 1'b0, 8'h00, 1'b1, 1'b0);
        chk("drain.last44", 32'(bus.IQ_out), 32'h44);
        step("hold", 1'b0, 8'h00, 1'b0, 1'b0);
        step("ld_empty", 1'b0, 8'h00, 1'b1, 1'b0);

        // Overflow: 55 is dropped and the flag sticks
        step("ofill", 1'b1, 8'h11, 1'b0, 1'b0);
        step("ofill", 1'b1, 8'h22, 1'b0, 1'b0);
        step("ofill", 1'b1, 8'h33, 1'b0, 1'b0);
        step("ofill", 1'b1, 8'h44, 1'b0, 1'b0);
        step("ovf_push", 1'b1, 8'h55, 1'b0, 1'b0);
        chk("ovf.flag_const", 32'(bus.IQ_ovf), 32'h1);
        for (int i = 0; i < 4; i++) step("odrain", 1'b0, 8'h00, 1'b1, 1'b0);
        step("odrain_empty", 1'b0, 8'h00, 1'b1, 1'b0);
        step("flush_clr", 1'b0, 8'h00, 1'b0, 1'b1);

        // Simultaneous push and load while full
        step("ffill", 1'b1, 8'h11, 1'b0, 1'b0);
        step("ffill", 1'b1, 8'h22, 1'b0, 1'b0);
        step("ffill", 1'b1, 8'h33, 1'b0, 1'b0);
        step("ffill", 1'b1, 8'h44, 1'b0, 1'b0);
        step("full_pushld", 1'b1, 8'h66, 1'b1, 1'b0);
        chk("full_pushld.out_const", 32'(bus.IQ_out), 32'h11);
        for (int i = 0; i < 4; i++) step("fdrain", 1'b0, 8'h00, 1'b1, 1'b0);
        chk("fdrain.last66", 32'(bus.IQ_out), 32'h66);

        // Empty corner: no bypass
        step("empty_pushld", 1'b1, 8'h77, 1'b1, 1'b0);
        chk("empty_pushld.out_hold", 32'(bus.IQ_out), 32'h66);
        step("empty_next_ld", 1'b0, 8'h00, 1'b1, 1'b0);
        chk("empty_next_ld.out77", 32'(bus.IQ_out), 32'h77);

        // Pointer wrap, then flush with concurrent push and load
        for (int i = 0; i < 6; i++) begin
            step("wrap_push", 1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
            step("wrap_pop", 1'b0, 8'h00, 1'b1, 1'b0);
        end
        step("pre_flush", 1'b1, 8'hA1, 1'b0, 1'b0);
        step("pre_flush", 1'b1, 8'hA2, 1'b0, 1'b0);
        step("flush_we_ld", 1'b1, 8'hB0, 1'b1, 1'b1);
        chk("flush.count_const", 32'(bus.IQ_count), 32'd0);
        chk("flush.out_hold", 32'(bus.IQ_out), 32'h85);
        step("post_flush_ld", 1'b0, 8'h00, 1'b1, 1'b0);
        step("c3_push", 1'b1, 8'hC3, 1'b0, 1'b0);
        step("c3_load", 1'b0, 8'h00, 1'b1, 1'b0);
        chk("c3_load.out_const", 32'(bus.IQ_out), 32'hC3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ir_queue.md
Name: ir_queue

Overview:
- Parametrised instruction prefetch queue with an output instruction register; generalises the single-stage instruction register.
- The fetch side pushes instruction words into a DEPTH-entry FIFO.
- The decode side loads the oldest word into an output register that holds its value until the next load.
- A flush input discards all queued words on a branch or jump. Sits between program memory fetch and the control unit decoder.

Parameters:
WIDTH, 8, instruction word width in bits (>=1)
DEPTH, 4, number of FIFO entries; power of two, >=2
CW, $clog2(DEPTH)+1, width of the occupancy count (derived localparam, not overridable)

Ports:
IQ_clk  input  1  clock; all state changes on rising edge
IQ_rst_n  input  1  asynchronous active-low reset
IQ_in  input  WIDTH  instruction word from fetch
IQ_we  input  1  push request for IQ_in
IQ_ld  input  1  load request: pop oldest entry into IQ_out
IQ_flush  input  1  discard all queued entries
IQ_out  output  WIDTH  current instruction register
IQ_out_valid  output  1  IQ_out holds an instruction loaded since the last reset/flush
IQ_full  output  1  count == DEPTH
IQ_empty  output  1  count == 0
IQ_count  output  CW  number of queued entries, 0..DEPTH
IQ_ovf  output  1  sticky overflow flag

Behaviour:
- Reset (IQ_rst_n low, asynchronous, any time including mid-operation):
  - IQ_out=0, IQ_out_valid=0, IQ_ovf=0.
  - Read/write pointers=0, IQ_count=0, IQ_empty=1, IQ_full=0.
  - Storage array contents are don't-care.
  - Deassertion is synchronous to the next edge in use; no operation takes effect in the cycle reset is low.
- All flags (IQ_full, IQ_empty) are decoded combinationally from the registered count. There are no combinational paths from inputs to outputs.
- Effective operations per rising edge, evaluated in priority order:
  1. IQ_flush=1:
     - Pointers and count go to 0; IQ_out_valid goes to 0; IQ_ovf clears.
     - IQ_out keeps its value.
     - Simultaneous IQ_we and IQ_ld are ignored; the pushed word is dropped.
  2. Otherwise:
     - pop = IQ_ld & ~IQ_empty.
     - push = IQ_we & (~IQ_full | pop).
- Pop:
  - IQ_out <= mem[rptr]; IQ_out_valid <= 1; rptr increments modulo DEPTH.
  - IQ_ld while empty is ignored: IQ_out and IQ_out_valid hold.
- Push:
  - mem[wptr] <= IQ_in; wptr increments modulo DEPTH.
- Push and pop in the same cycle:
  - Count unchanged. Allowed when full, because the pop frees a slot in the same edge.
  - When empty, only the push happens. There is no bypass: a word pushed in cycle N is loadable in cycle N+1 at the earliest, and appears on IQ_out after that edge.
- Count: +1 on push only, -1 on pop only, unchanged on both or neither. Never exceeds DEPTH and never underflows.
- Overflow:
  - IQ_we=1 while full and no pop: the word is dropped, storage and pointers are unchanged, and IQ_ovf sets.
  - IQ_ovf stays set until flush or reset.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. FIFO order is preserved across the wrap.
- Latency:
  - Push to IQ_count update: 1 edge.
  - IQ_ld to IQ_out update: 1 edge.
  - IQ_out is stable between loads, with the same hold semantics as the single-stage instruction register.

Test Plan:
- Reset/idle: assert IQ_rst_n=0 mid-cycle after 3 pushes -> IQ_out=0, IQ_count=0, IQ_empty=1, IQ_out_valid=0 immediately, without waiting for a clock edge.
- Fill/drain (WIDTH=8, DEPTH=4): push 8'h11,8'h22,8'h33,8'h44 -> IQ_full=1, IQ_count=4; then 4 loads -> IQ_out sequence 11,22,33,44, IQ_empty=1, IQ_out holds 44.
- Overflow: at full, push 8'h55 with no load -> IQ_ovf=1, IQ_count=4; the subsequent drain yields 11..44 only, with no 55.
- Full push+load: at full, push 8'h66 with IQ_ld same cycle -> IQ_out=11, IQ_count=4, IQ_ovf=0; the drain then yields 22,33,44,66.
- Empty corner: empty queue, IQ_ld with IQ_we=1 and IQ_in=8'h77 -> IQ_out unchanged, IQ_count=1; the next IQ_ld gives IQ_out=77.
- Flush priority and wrap: run 6 push/pop pairs so the pointers wrap; push A1,A2, then IQ_flush together with IQ_we (8'hB0) and IQ_ld -> IQ_count=0, IQ_out unchanged, IQ_out_valid=0, IQ_ovf=0; push C3 and load -> IQ_out=C3.
